// File: rtl/regfile_port_scheduler_if.sv
// regfile_port_scheduler_if
//   Bundles every non-clock/reset signal of the write-port scheduler.
//   slave  : the scheduler (takes requests, drives grants, hazards and the
//            register-file write port).
//   master : the surrounding pipeline / bench (drives requests and read
//            addresses, observes grants and hazards).
//   Macro REGFILE_BYPASS_EN adds the forwarding outputs fwd_rs1_* / fwd_rs2_*.
interface regfile_port_scheduler_if;
  logic        req0_valid;
  logic [4:0]  req0_rd;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_rd;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  addr_rs1;
  logic [4:0]  addr_rs2;
  logic        hazard_rs1;
  logic        hazard_rs2;
  logic        rf_write_enable;
  logic [4:0]  rf_addr_rd;
  logic [31:0] rf_data_rd;
`ifdef REGFILE_BYPASS_EN
  logic        fwd_rs1_valid;
  logic [31:0] fwd_rs1_data;
  logic        fwd_rs2_valid;
  logic [31:0] fwd_rs2_data;
`endif

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    input  req1_valid, req1_rd, req1_data,
    input  issue_valid, issue_rd,
    input  addr_rs1, addr_rs2,
    output req0_ready, req1_ready, issue_ready,
    output hazard_rs1, hazard_rs2,
`ifdef REGFILE_BYPASS_EN
    output fwd_rs1_valid, fwd_rs1_data, fwd_rs2_valid, fwd_rs2_data,
`endif
    output rf_write_enable, rf_addr_rd, rf_data_rd
  );

  modport master (
    output req0_valid, req0_rd, req0_data,
    output req1_valid, req1_rd, req1_data,
    output issue_valid, issue_rd,
    output addr_rs1, addr_rs2,
    input  req0_ready, req1_ready, issue_ready,
    input  hazard_rs1, hazard_rs2,
`ifdef REGFILE_BYPASS_EN
    input  fwd_rs1_valid, fwd_rs1_data, fwd_rs2_valid, fwd_rs2_data,
`endif
    input  rf_write_enable, rf_addr_rd, rf_data_rd
  );
endinterface

// File: rtl/regfile_port_scheduler.sv
// regfile_port_scheduler
//   Shares the single write port of a 32x32 register file between the ALU
//   writeback (req0) and the load writeback (req1). req1 wins by default;
//   req0 is force-granted after STARVE_LIMIT consecutive lost cycles.
//   A per-register pending-write counter (claimed by the issue stage,
//   released when the staged write is presented) drives RAW hazard flags.
//
// Ports
//   i_clock  : system clock, rising edge
//   i_reset  : asynchronous, active-high reset
//   bus      : regfile_port_scheduler_if.slave
//              req0_*/req1_* writeback handshakes (ready combinational)
//              issue_* destination claim (ready combinational)
//              addr_rs1/2 -> hazard_rs1/2
//              rf_write_enable/rf_addr_rd/rf_data_rd (registered)
//
// Macro REGFILE_BYPASS_EN: adds fwd_rs1/2_valid/data, forwarding the staged
//   write; a read whose only outstanding write is the staged one is then
//   not flagged as a hazard.
module regfile_port_scheduler #(
  parameter int STARVE_LIMIT = 4,
  parameter int PEND_W       = 2
) (
  input logic                    i_clock,
  input logic                    i_reset,
  regfile_port_scheduler_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [SW-1:0]     r_starve;
  logic              r_we;
  logic [4:0]        r_addr;
  logic [31:0]       r_data;
  logic [PEND_W-1:0] r_cnt [32];

  logic        w_g0;
  logic        w_g1;
  logic        w_issue_ok;
  logic [31:0] w_inc;
  logic [31:0] w_dec;
  logic        w_haz1_base;
  logic        w_haz2_base;

  assign w_g0 = bus.req0_valid && (!bus.req1_valid || (r_starve == SW'(STARVE_LIMIT)));
  assign w_g1 = bus.req1_valid && !w_g0;

  assign w_issue_ok = (bus.issue_rd == 5'd0) || (r_cnt[bus.issue_rd] != CNT_MAX);

  assign bus.req0_ready  = w_g0;
  assign bus.req1_ready  = w_g1;
  assign bus.issue_ready = w_issue_ok;

  // Decrement is suppressed at zero so a stray write never wraps the count.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 1; i < 32; i++) begin
      w_inc[i] = bus.issue_valid && w_issue_ok && (bus.issue_rd == 5'(i));
      w_dec[i] = r_we && (r_addr == 5'(i)) && (r_cnt[i] != '0);
    end
  end

  assign w_haz1_base = (bus.addr_rs1 != 5'd0) && (r_cnt[bus.addr_rs1] != '0);
  assign w_haz2_base = (bus.addr_rs2 != 5'd0) && (r_cnt[bus.addr_rs2] != '0);

`ifdef REGFILE_BYPASS_EN
  logic w_fwd1;
  logic w_fwd2;
  assign w_fwd1 = r_we && (r_addr == bus.addr_rs1) && (bus.addr_rs1 != 5'd0);
  assign w_fwd2 = r_we && (r_addr == bus.addr_rs2) && (bus.addr_rs2 != 5'd0);
  assign bus.fwd_rs1_valid = w_fwd1;
  assign bus.fwd_rs2_valid = w_fwd2;
  assign bus.fwd_rs1_data  = r_data;
  assign bus.fwd_rs2_data  = r_data;
  // The staged write is the last outstanding one: forwarding covers it.
  assign bus.hazard_rs1 = w_haz1_base && !(w_fwd1 && (r_cnt[bus.addr_rs1] == CNT_ONE));
  assign bus.hazard_rs2 = w_haz2_base && !(w_fwd2 && (r_cnt[bus.addr_rs2] == CNT_ONE));
`else
  assign bus.hazard_rs1 = w_haz1_base;
  assign bus.hazard_rs2 = w_haz2_base;
`endif

  assign bus.rf_write_enable = r_we;
  assign bus.rf_addr_rd      = r_addr;
  assign bus.rf_data_rd      = r_data;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_starve <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      for (int i = 0; i < 32; i++) r_cnt[i] <= '0;
    end else begin
      if (bus.req0_valid && !w_g0) begin
        if (r_starve != SW'(STARVE_LIMIT)) r_starve <= r_starve + SW'(1);
      end else begin
        r_starve <= '0;
      end

      // rd=0 transfers are accepted and staged but never enable a write.
      if (w_g0) begin
        r_addr <= bus.req0_rd;
        r_data <= bus.req0_data;
        r_we   <= (bus.req0_rd != 5'd0);
      end else if (w_g1) begin
        r_addr <= bus.req1_rd;
        r_data <= bus.req1_data;
        r_we   <= (bus.req1_rd != 5'd0);
      end else begin
        r_we   <= 1'b0;
      end

      for (int i = 1; i < 32; i++) begin
        if (w_inc[i] && !w_dec[i])      r_cnt[i] <= r_cnt[i] + CNT_ONE;
        else if (w_dec[i] && !w_inc[i]) r_cnt[i] <= r_cnt[i] - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_regfile_port_scheduler.sv
module tb_regfile_port_scheduler;
  localparam int LIMIT = 4;
  localparam int CMAX  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  regfile_port_scheduler_if bus();

  regfile_port_scheduler #(.STARVE_LIMIT(LIMIT), .PEND_W(2)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // reference model: outstanding writes per register, lost-cycle count, staged write
  int          m_cnt [32];
  int          m_starve;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 0; bus.req0_rd = 0; bus.req0_data = 0;
    bus.req1_valid = 0; bus.req1_rd = 0; bus.req1_data = 0;
    bus.issue_valid = 0; bus.issue_rd = 0;
    bus.addr_rs1 = 0; bus.addr_rs2 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_starve = 0; m_we = 0; m_addr = 0; m_data = 0;
  endtask

  function automatic bit m_g0();
    return bus.req0_valid && (!bus.req1_valid || m_starve == LIMIT);
  endfunction

  function automatic bit m_g1();
    return bus.req1_valid && !m_g0();
  endfunction

  function automatic bit m_issue_ok();
    return bus.issue_rd == 0 || m_cnt[bus.issue_rd] < CMAX;
  endfunction

  function automatic bit m_haz(input logic [4:0] a);
    bit h;
    h = (a != 0) && (m_cnt[a] != 0);
`ifdef REGFILE_BYPASS_EN
    if (m_we && m_addr == a && a != 0 && m_cnt[a] == 1) h = 0;
`endif
    return h;
  endfunction

  // advance the model across one clock edge using the currently driven inputs
  function automatic void model_edge();
    bit g0, g1, inc;
    int inc_rd;
    g0 = m_g0();
    g1 = m_g1();
    inc = bus.issue_valid && m_issue_ok() && bus.issue_rd != 0;
    inc_rd = bus.issue_rd;
    if (m_we && m_cnt[m_addr] > 0) m_cnt[m_addr] = m_cnt[m_addr] - 1;
    if (inc) m_cnt[inc_rd] = m_cnt[inc_rd] + 1;
    if (bus.req0_valid && !g0) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
    else m_starve = 0;
    if (g0) begin m_addr = bus.req0_rd; m_data = bus.req0_data; m_we = bus.req0_rd != 0; end
    else if (g1) begin m_addr = bus.req1_rd; m_data = bus.req1_data; m_we = bus.req1_rd != 0; end
    else m_we = 0;
  endfunction

  task automatic test_reset();
    do_reset();
    bus.addr_rs1 = 5; bus.addr_rs2 = 31;
    #1;
    checks++;
    if (bus.rf_write_enable !== 1'b0 || bus.rf_addr_rd !== 5'd0 || bus.rf_data_rd !== 32'd0) begin
      failures++;
      $display("FAIL reset_rf: we=%b addr=%0d data=%h required 0/0/0",
               bus.rf_write_enable, bus.rf_addr_rd, bus.rf_data_rd);
    end
    checks++;
    if (bus.hazard_rs1 !== 1'b0 || bus.hazard_rs2 !== 1'b0 || bus.issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_flags: haz1=%b haz2=%b issue_ready=%b required 0/0/1",
               bus.hazard_rs1, bus.hazard_rs2, bus.issue_ready);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    bus.addr_rs1 = 5;
    bus.issue_valid = 1; bus.issue_rd = 5;
    #1;
    checks++;
    if (bus.hazard_rs1 !== 1'b0 || bus.issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL sw_pre_issue: haz=%b ready=%b required 0/1", bus.hazard_rs1, bus.issue_ready);
    end
    tick();
    bus.issue_valid = 0;
    bus.req0_valid = 1; bus.req0_rd = 5; bus.req0_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (bus.hazard_rs1 !== 1'b1 || bus.req0_ready !== 1'b1 || bus.rf_write_enable !== 1'b0) begin
      failures++;
      $display("FAIL sw_grant: haz=%b req0_ready=%b we=%b required 1/1/0",
               bus.hazard_rs1, bus.req0_ready, bus.rf_write_enable);
    end
    tick();
    bus.req0_valid = 0;
    #1;
    checks++;
    if (bus.rf_write_enable !== 1'b1 || bus.rf_addr_rd !== 5'd5 || bus.rf_data_rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL sw_staged: we=%b addr=%0d data=%h required 1/5/deadbeef",
               bus.rf_write_enable, bus.rf_addr_rd, bus.rf_data_rd);
    end
`ifdef REGFILE_BYPASS_EN
    checks++;
    if (bus.hazard_rs1 !== 1'b0 || bus.fwd_rs1_valid !== 1'b1 || bus.fwd_rs1_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL sw_staged_fwd: haz=%b fwd=%b data=%h required 0/1/deadbeef",
               bus.hazard_rs1, bus.fwd_rs1_valid, bus.fwd_rs1_data);
    end
`else
    checks++;
    if (bus.hazard_rs1 !== 1'b1) begin
      failures++;
      $display("FAIL sw_staged_haz: haz=%b required 1", bus.hazard_rs1);
    end
`endif
    tick();
    #1;
    checks++;
    if (bus.hazard_rs1 !== 1'b0 || bus.rf_write_enable !== 1'b0) begin
      failures++;
      $display("FAIL sw_post_commit: haz=%b we=%b required 0/0", bus.hazard_rs1, bus.rf_write_enable);
    end
  endtask

  task automatic test_contention();
    do_reset();
    bus.req0_valid = 1; bus.req0_rd = 1; bus.req0_data = 32'h1111;
    bus.req1_valid = 1; bus.req1_rd = 2; bus.req1_data = 32'h2222;
    bus.addr_rs1 = 2;
    for (int c = 0; c < 15; c++) begin
      bit want0;
      want0 = (c % 5) == 4;
      #1;
      checks++;
      if (bus.req0_ready !== want0 || bus.req1_ready !== !want0) begin
        failures++;
        $display("FAIL contention_c%0d: r0=%b r1=%b required %b/%b",
                 c, bus.req0_ready, bus.req1_ready, want0, !want0);
      end
      tick();
    end
    idle_inputs();
    bus.addr_rs1 = 2;
    tick();
    #1;
    // writes with no claim must leave the counter at zero, not wrap it
    checks++;
    if (bus.hazard_rs1 !== 1'b0) begin
      failures++;
      $display("FAIL contention_nowrap: haz=%b required 0", bus.hazard_rs1);
    end
  endtask

  task automatic test_rd_zero();
    do_reset();
    bus.req1_valid = 1; bus.req1_rd = 0; bus.req1_data = 32'hCAFE;
    #1;
    checks++;
    if (bus.req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL rd0_ready: ready=%b required 1", bus.req1_ready);
    end
    tick();
    bus.req1_valid = 0;
    bus.issue_valid = 1; bus.issue_rd = 0;
    #1;
    checks++;
    if (bus.rf_write_enable !== 1'b0 || bus.issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL rd0_nowrite: we=%b issue_ready=%b required 0/1", bus.rf_write_enable, bus.issue_ready);
    end
    tick();
    bus.issue_valid = 0;
    for (int a = 0; a < 32; a++) begin
      bus.addr_rs1 = 5'(a); bus.addr_rs2 = 5'(31 - a);
      #1;
      checks++;
      if (bus.hazard_rs1 !== 1'b0 || bus.hazard_rs2 !== 1'b0) begin
        failures++;
        $display("FAIL rd0_haz_a%0d: h1=%b h2=%b required 0/0", a, bus.hazard_rs1, bus.hazard_rs2);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    bus.addr_rs1 = 7;
    for (int k = 0; k < 3; k++) begin
      bus.issue_valid = 1; bus.issue_rd = 7;
      #1;
      checks++;
      if (bus.issue_ready !== 1'b1) begin
        failures++;
        $display("FAIL sat_claim%0d: issue_ready=%b required 1", k, bus.issue_ready);
      end
      tick();
    end
    #1;
    checks++;
    if (bus.issue_ready !== 1'b0 || bus.hazard_rs1 !== 1'b1) begin
      failures++;
      $display("FAIL sat_full: issue_ready=%b haz=%b required 0/1", bus.issue_ready, bus.hazard_rs1);
    end
    bus.issue_valid = 0;
    for (int j = 0; j < 3; j++) begin
      bus.req1_valid = 1; bus.req1_rd = 7; bus.req1_data = 32'(j);
      tick();
      bus.req1_valid = 0;
      tick();
      bus.issue_rd = 7;
      #1;
      checks++;
      if (bus.issue_ready !== 1'b1) begin
        failures++;
        $display("FAIL sat_ready_after%0d: issue_ready=%b required 1", j, bus.issue_ready);
      end
      checks++;
      if (bus.hazard_rs1 !== (j < 2)) begin
        failures++;
        $display("FAIL sat_haz_after%0d: haz=%b required %b", j, bus.hazard_rs1, (j < 2));
      end
    end
  endtask

  task automatic test_same_edge();
    do_reset();
    bus.addr_rs2 = 9;
    bus.issue_valid = 1; bus.issue_rd = 9;
    tick();
    bus.issue_valid = 0;
    bus.req0_valid = 1; bus.req0_rd = 9; bus.req0_data = 32'h99;
    tick();
    bus.req0_valid = 0;
    bus.issue_valid = 1; bus.issue_rd = 9;
    #1;
    checks++;
    if (bus.rf_write_enable !== 1'b1 || bus.issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL same_setup: we=%b issue_ready=%b required 1/1", bus.rf_write_enable, bus.issue_ready);
    end
    tick();
    bus.issue_valid = 0;
    #1;
    checks++;
    if (bus.hazard_rs2 !== 1'b1) begin
      failures++;
      $display("FAIL same_edge_haz: haz=%b required 1", bus.hazard_rs2);
    end
    bus.req0_valid = 1;
    tick();
    bus.req0_valid = 0;
    tick();
    #1;
    // a single further commit must drain it: count was exactly 1
    checks++;
    if (bus.hazard_rs2 !== 1'b0) begin
      failures++;
      $display("FAIL same_edge_count: haz=%b required 0", bus.hazard_rs2);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.addr_rs1 = 3; bus.addr_rs2 = 3;
    bus.issue_valid = 1; bus.issue_rd = 3;
    tick();
    bus.issue_valid = 0;
    bus.req1_valid = 1; bus.req1_rd = 3; bus.req1_data = 32'h3333;
    tick();
    bus.req1_valid = 0;
    #1;
    checks++;
    if (bus.rf_write_enable !== 1'b1) begin
      failures++;
      $display("FAIL areset_staged: we=%b required 1", bus.rf_write_enable);
    end
`ifdef REGFILE_BYPASS_EN
    checks++;
    if (bus.fwd_rs1_valid !== 1'b1 || bus.hazard_rs1 !== 1'b0) begin
      failures++;
      $display("FAIL areset_fwd: fwd=%b haz=%b required 1/0", bus.fwd_rs1_valid, bus.hazard_rs1);
    end
`endif
    #2;
    rst = 1;
    #1;
    checks++;
    if (bus.rf_write_enable !== 1'b0 || bus.hazard_rs1 !== 1'b0 || bus.hazard_rs2 !== 1'b0) begin
      failures++;
      $display("FAIL areset_immediate: we=%b h1=%b h2=%b required 0/0/0",
               bus.rf_write_enable, bus.hazard_rs1, bus.hazard_rs2);
    end
    tick();
    rst = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bus.req0_valid  = ($urandom_range(0, 99) < 55);
      bus.req0_rd     = 5'($urandom_range(0, 7));
      bus.req0_data   = $urandom;
      bus.req1_valid  = ($urandom_range(0, 99) < 45);
      bus.req1_rd     = 5'($urandom_range(0, 7));
      bus.req1_data   = $urandom;
      bus.issue_valid = ($urandom_range(0, 99) < 60);
      bus.issue_rd    = 5'($urandom_range(0, 7));
      bus.addr_rs1    = 5'($urandom_range(0, 7));
      bus.addr_rs2    = 5'($urandom_range(0, 7));
      #1;
      checks++;
      if (bus.req0_ready !== m_g0() || bus.req1_ready !== m_g1() || bus.issue_ready !== m_issue_ok()) begin
        failures++;
        $display("FAIL rand_ready_c%0d: r0=%b r1=%b iss=%b required %b/%b/%b", c,
                 bus.req0_ready, bus.req1_ready, bus.issue_ready, m_g0(), m_g1(), m_issue_ok());
      end
      checks++;
      if (bus.hazard_rs1 !== m_haz(bus.addr_rs1) || bus.hazard_rs2 !== m_haz(bus.addr_rs2)) begin
        failures++;
        $display("FAIL rand_haz_c%0d: h1=%b h2=%b required %b/%b", c,
                 bus.hazard_rs1, bus.hazard_rs2, m_haz(bus.addr_rs1), m_haz(bus.addr_rs2));
      end
      checks++;
      if (bus.rf_write_enable !== m_we || bus.rf_addr_rd !== m_addr || bus.rf_data_rd !== m_data) begin
        failures++;
        $display("FAIL rand_rf_c%0d: we=%b addr=%0d data=%h required %b/%0d/%h", c,
                 bus.rf_write_enable, bus.rf_addr_rd, bus.rf_data_rd, m_we, m_addr, m_data);
      end
      tick();
      model_edge();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_write();
    test_contention();
    test_rd_zero();
    test_saturation();
    test_same_edge();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_port_scheduler.md
Name: regfile_port_scheduler

Overview:
- Controller in front of the single-write-port 32x32 register file.
- Arbitrates two writeback requesters (req0 = ALU writeback, req1 = load writeback) onto the one write port using valid/ready handshakes.
- Keeps a per-register pending-write scoreboard, fed by the issue stage, and flags read-after-write hazards on the rs1/rs2 read addresses.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles req0 may wait behind req1 before req0 is force-granted.
- PEND_W, 2, width of each per-register pending-write counter (max outstanding writes per register = 2^PEND_W-1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  ALU writeback request.
- req0_rd  in  5  destination register for req0.
- req0_data  in  32  write data for req0.
- req0_ready  out  1  grant to req0; combinational.
- req1_valid  in  1  load writeback request.
- req1_rd  in  5  destination register for req1.
- req1_data  in  32  write data for req1.
- req1_ready  out  1  grant to req1; combinational.
- issue_valid  in  1  issue stage claims a destination register.
- issue_rd  in  5  claimed destination register.
- issue_ready  out  1  claim accepted; combinational.
- addr_rs1  in  5  read address 1, as presented to the register file.
- addr_rs2  in  5  read address 2, as presented to the register file.
- hazard_rs1  out  1  addr_rs1 has an outstanding write.
- hazard_rs2  out  1  addr_rs2 has an outstanding write.
- rf_write_enable  out  1  to register file write_enable; registered.
- rf_addr_rd  out  5  to register file addr_rd; registered.
- rf_data_rd  out  32  to register file data_rd; registered.

Behaviour:
- Reset (async, immediate): rf_write_enable=0, rf_addr_rd=0, rf_data_rd=0, all pending counters=0, starve counter=0. Reset mid-operation discards all outstanding claims and any staged write.
- Arbitration, combinational, in the same cycle as valid:
  - Default: req1 has priority.
  - req0_ready = req0_valid && (!req1_valid || starve==STARVE_LIMIT).
  - req1_ready = req1_valid && !req0_ready.
  - At most one grant per cycle.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, on each edge where req0_valid && !req0_ready.
  - Clears on a req0 grant or when req0_valid=0.
- Staging: on the edge of an accepted transfer (valid && ready), rf_addr_rd and rf_data_rd load the winner's rd and data. rf_write_enable=1 for exactly that following cycle, only if the winner's rd!=0.
  - rd=0 requests are accepted and dropped: no write, no counter change.
  - With no grant, rf_write_enable=0 on the next cycle; rf_addr_rd and rf_data_rd hold.
  - The register file commits at the edge that ends the rf_write_enable=1 cycle. Write latency from grant edge to committed data = 2 edges.
- Scoreboard, one PEND_W-bit counter per register (x0 hard-wired to 0):
  - Increment on the edge where issue_valid && issue_ready && issue_rd!=0.
  - Decrement on the edge where rf_write_enable=1, for rf_addr_rd.
  - Increment and decrement of the same register on the same edge: net unchanged.
  - issue_ready = !(issue_rd!=0 && count[issue_rd]==max). issue_rd=0 is always ready.
  - Decrement at 0 is a protocol error: the counter holds at 0 (no wrap).
- Hazards: hazard_rsX = (addr_rsX!=0) && count[addr_rsX]!=0. This covers the staged cycle, because the register file read is still stale then.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: adds outputs fwd_rs1_valid, fwd_rs1_data[31:0], fwd_rs2_valid, fwd_rs2_data[31:0].
  - fwd_rsX_valid = rf_write_enable && rf_addr_rd==addr_rsX && addr_rsX!=0.
  - fwd_rsX_data = rf_data_rd.
  - When fwd_rsX_valid=1 and count[addr_rsX]==1, hazard_rsX=0 (the staged write is the last outstanding one).
- Undefined: ports absent; hazard as in the base Behaviour.

Test Plan:
- Reset then single write: issue x5, then req0 x5=0xDEADBEEF. Required: hazard_rs1 (addr_rs1=5) is 1 from the issue edge until the commit edge; rf_write_enable=1 one cycle after the grant; hazard_rs1=0 afterwards.
- Contention: req0 and req1 both valid continuously, STARVE_LIMIT=4. Required: grant pattern req1 x4, req0 x1, repeating; no cycle with both ready high.
- rd=0: req1_valid with req1_rd=0. Required: req1_ready=1; rf_write_enable stays 0; all counters unchanged; issue x0 leaves hazard low.
- Saturation: issue x7 three times (PEND_W=2). Required: issue_ready drops after the 3rd claim. One commit to x7 re-raises issue_ready; hazard on x7 stays 1 until the 3rd commit.
- Same-edge issue/commit: commit of x9 on the same edge as issue x9 with count=1. Required: count stays 1; hazard stays 1.
- Async reset mid-write: assert reset while rf_write_enable=1. Required: rf_write_enable=0 immediately, without waiting for a clock edge; all hazards 0. With REGFILE_BYPASS_EN, fwd_rs1_valid=1 and hazard_rs1=0 in the staged cycle, count=1.
